prog_rom_loader: RTL and testbench

- Program-memory responder for the 4-bit CPU fetch interface.
- Holds a 16 x 8 program store and returns the instruction byte for the fetch address in the same cycle.
- Reloads the store from a host over a UART 8N1 serial line.
- Holds the CPU in reset while loading, and after a failed load.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/uart_rx_byte.sv | 98 +++++++++
 rtl/prog_rom_loader.sv | 112 +++++++++++
 tb/tb_prog_rom_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encodings for the program-ROM loader.
package prog_loader_pkg;

    localparam int unsigned MEM_DEPTH         = 16;
    localparam int unsigned MEM_AW            = 4;
    localparam int unsigned MEM_DW            = 8;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: synchroniser, start-bit glitch filter, centre sampling.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_CNT = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_CNT = CLKS_PER_BIT - 1;

    rx_state_t   state, state_next;
    logic [CW-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift_next;
    logic        valid_next, ferr_next;
    logic        rx_s1, rx_s2, rx_s3;

    // Synchroniser (s1/s2) plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_idx    <= bit_idx_next;
            byte_data  <= shift_next;
            byte_valid <= valid_next;
            frame_err  <= ferr_next;
        end
    end

    // Next-state: half-bit start check, then sample every full bit period.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + CW'(1);
        bit_idx_next  = bit_idx;
        shift_next    = byte_data;
        valid_next    = 1'b0;
        ferr_next     = 1'b0;
        case (state)
            RX_IDLE: begin
                baud_cnt_next = '0;
                if (rx_s3 && !rx_s2) state_next = RX_START;
            end
            RX_START: begin
                if (baud_cnt == CW'(HALF_CNT)) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt == CW'(FULL_CNT)) begin
                    baud_cnt_next = '0;
                    shift_next    = {rx_s2, byte_data[7:1]};
                    bit_idx_next  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baud_cnt == CW'(FULL_CNT)) begin
                    baud_cnt_next = '0;
                    valid_next    = rx_s2;
                    ferr_next     = !rx_s2;
                    state_next    = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/prog_rom_loader.sv
// 16x8 program store with combinational fetch, reloaded over UART with checksum.
module prog_rom_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [MEM_AW-1:0] addr,
    output logic [MEM_DW-1:0] data,
    input  logic              uart_rx,
    output logic              cpu_n_reset,
    output logic              loading,
    output logic              load_ok,
    output logic              load_err
);

    logic              byte_valid, frame_err;
    logic [7:0]        byte_data;

    loader_state_t     state, state_next;
    logic [MEM_AW-1:0] cnt, cnt_next;
    logic [MEM_DW-1:0] sum, sum_next;
    logic              wr_en;
    logic              cpu_n_reset_next, load_ok_next, load_err_next;
    logic [MEM_DW-1:0] mem [MEM_DEPTH];

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Zero-latency fetch.
    assign data = mem[addr];

    // State, counters, flags and memory; reset also clears the store.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sum         <= '0;
            cpu_n_reset <= 1'b1;
            loading     <= 1'b0;
            load_ok     <= 1'b0;
            load_err    <= 1'b0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            sum         <= sum_next;
            cpu_n_reset <= cpu_n_reset_next;
            loading     <= (state_next != IDLE);
            load_ok     <= load_ok_next;
            load_err    <= load_err_next;
            if (wr_en) mem[cnt] <= byte_data;
        end
    end

    // Frame sequencing: sync byte, 16 data bytes, then checksum.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        sum_next         = sum;
        wr_en            = 1'b0;
        cpu_n_reset_next = cpu_n_reset;
        load_ok_next     = 1'b0;
        load_err_next    = load_err;
        case (state)
            IDLE: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_next       = LOAD;
                    cnt_next         = '0;
                    sum_next         = '0;
                    cpu_n_reset_next = 1'b0;
                end
            end
            LOAD: begin
                if (frame_err) begin
                    state_next    = IDLE;
                    load_err_next = 1'b1;
                end else if (byte_valid) begin
                    wr_en    = 1'b1;
                    sum_next = sum + byte_data;
                    cnt_next = cnt + MEM_AW'(1);
                    if (cnt == MEM_AW'(MEM_DEPTH - 1)) state_next = CHECK;
                end
            end
            CHECK: begin
                if (frame_err) begin
                    state_next    = IDLE;
                    load_err_next = 1'b1;
                end else if (byte_valid) begin
                    state_next = IDLE;
                    if (byte_data == sum) begin
                        cpu_n_reset_next = 1'b1;
                        load_err_next    = 1'b0;
                        load_ok_next     = 1'b1;
                    end else begin
                        load_err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_rom_loader.sv
// Directed bench for prog_rom_loader with a fast UART bit period.
module tb_prog_rom_loader;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic [3:0] addr = 4'd0;
    logic [7:0] data;
    logic       uart_rx = 1'b1;
    logic       cpu_n_reset, loading, load_ok, load_err;

    int vectors = 0;
    int miscompares = 0;
    int ok_pulses = 0;
    int loading_cycles = 0;
    int ok_before, ld_before;
    logic [7:0] fr [16];
    logic [7:0] ck;

    prog_rom_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .addr        (addr),
        .data        (data),
        .uart_rx     (uart_rx),
        .cpu_n_reset (cpu_n_reset),
        .loading     (loading),
        .load_ok     (load_ok),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    // Count load_ok high cycles and loading high cycles.
    always @(negedge clk) begin
        if (load_ok) ok_pulses++;
        if (loading) loading_cycles++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] frame_sum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + fr[i];
        return s;
    endfunction

    task automatic check_mem_frame(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            check(tag, data, fr[i]);
        end
    endtask

    task automatic check_mem_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            check(tag, data, 8'h00);
        end
    endtask

    // Sync byte, 16 data bytes, checksum, with loading/cpu checks along the way.
    task automatic send_frame(input logic [7:0] cks);
        send_byte(8'hA5, 1'b1);
        settle();
        check("loading_after_sync", {7'd0, loading}, 8'd1);
        check("cpu_held_after_sync", {7'd0, cpu_n_reset}, 8'd0);
        for (int i = 0; i < 16; i++) send_byte(fr[i], 1'b1);
        settle();
        check("loading_before_cks", {7'd0, loading}, 8'd1);
        check("cpu_held_before_cks", {7'd0, cpu_n_reset}, 8'd0);
        send_byte(cks, 1'b1);
        settle();
        check("loading_after_cks", {7'd0, loading}, 8'd0);
    endtask

    initial begin
        // Reset and initial state.
        @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check_mem_zero("reset_mem");
        check("reset_cpu_n_reset", {7'd0, cpu_n_reset}, 8'd1);
        check("reset_load_err", {7'd0, load_err}, 8'd0);
        check("reset_loading", {7'd0, loading}, 8'd0);
        check("reset_load_ok", {7'd0, load_ok}, 8'd0);

        // Good frame 31 41 0F 00...; checksum 0x31+0x41+0x0F = 0x81.
        for (int i = 0; i < 16; i++) fr[i] = 8'h00;
        fr[0] = 8'h31; fr[1] = 8'h41; fr[2] = 8'h0F;
        ck = frame_sum();
        check("cks_value", ck, 8'h81);
        ok_before = ok_pulses;
        send_frame(ck);
        check("good_ok_pulses", 8'(ok_pulses - ok_before), 8'd1);
        check("good_cpu_n_reset", {7'd0, cpu_n_reset}, 8'd1);
        check("good_load_err", {7'd0, load_err}, 8'd0);
        addr = 4'd0; #1; check("good_word0", data, 8'h31);
        addr = 4'd1; #1; check("good_word1", data, 8'h41);
        addr = 4'd2; #1; check("good_word2", data, 8'h0F);
        addr = 4'd3; #1; check("good_word3", data, 8'h00);

        // Same frame, bad checksum.
        ok_before = ok_pulses;
        send_frame(ck ^ 8'h01);
        check("badcks_load_err", {7'd0, load_err}, 8'd1);
        check("badcks_cpu_held", {7'd0, cpu_n_reset}, 8'd0);
        check("badcks_no_ok", 8'(ok_pulses - ok_before), 8'd0);

        // Correct frame clears the error.
        ok_before = ok_pulses;
        send_frame(ck);
        check("recover_load_err", {7'd0, load_err}, 8'd0);
        check("recover_cpu_n_reset", {7'd0, cpu_n_reset}, 8'd1);
        check("recover_ok_pulses", 8'(ok_pulses - ok_before), 8'd1);

        // Framing error after 5 data bytes.
        ok_before = ok_pulses;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        settle();
        check("ferr_load_err", {7'd0, load_err}, 8'd1);
        check("ferr_loading", {7'd0, loading}, 8'd0);
        check("ferr_cpu_held", {7'd0, cpu_n_reset}, 8'd0);
        check("ferr_no_ok", 8'(ok_pulses - ok_before), 8'd0);
        for (int i = 0; i < 5; i++) fr[i] = 8'(8'h11 * (i + 1));
        fr[5] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            addr = 4'(i);
            #1;
            check("ferr_word", data, fr[i]);
        end

        // Non-sync bytes and a short glitch while idle.
        ld_before = loading_cycles;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12) @(negedge clk);
        check("idle_noise_loading", 8'(loading_cycles - ld_before), 8'd0);
        for (int i = 0; i < 6; i++) begin
            addr = 4'(i);
            #1;
            check("idle_noise_word", data, fr[i]);
        end
        check("idle_noise_load_err", {7'd0, load_err}, 8'd1);

        // Reset in the middle of the 8th data byte.
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 7; i++) send_byte(8'(8'hC0 + i), 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("midbyte_loading", {7'd0, loading}, 8'd1);
        n_reset = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("abort_cpu_n_reset", {7'd0, cpu_n_reset}, 8'd1);
        check("abort_loading", {7'd0, loading}, 8'd0);
        check("abort_load_ok", {7'd0, load_ok}, 8'd0);
        check("abort_load_err", {7'd0, load_err}, 8'd0);
        check_mem_zero("abort_mem");
        repeat (20) @(negedge clk);

        // Fresh full frame after the abort: 01..10, checksum 0x88.
        for (int i = 0; i < 16; i++) fr[i] = 8'(i + 1);
        ck = frame_sum();
        check("cks2_value", ck, 8'h88);
        ok_before = ok_pulses;
        send_frame(ck);
        check("final_ok_pulses", 8'(ok_pulses - ok_before), 8'd1);
        check("final_cpu_n_reset", {7'd0, cpu_n_reset}, 8'd1);
        check("final_load_err", {7'd0, load_err}, 8'd0);
        check_mem_frame("final_mem");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
